// File: rtl/led_display_scheduler.sv
// ============================================================================
// Module   : led_display_scheduler
// Purpose  : Frame-synchronous round-robin owner of the tlc5920 LED pattern,
//            with minimum hold time and per-requester blink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_display_scheduler #(
    parameter int g_requesters      = 3,
    parameter int g_min_hold_frames = 4,
    parameter int g_blink_frames    = 50
) (
    input  logic [1:0]                    ClkRs_ix,     // {clk, reset}
    input  logic                          FrameDone_i,
    input  logic [g_requesters-1:0]       Request_ib,
    input  logic [g_requesters-1:0]       Blink_ib,
    input  logic [g_requesters*128-1:0]   ReqData_ib,
    input  logic [127:0]                  Default_ib,
    output logic [127:0]                  ledData_ob,
    output logic [g_requesters-1:0]       Grant_ob,
    output logic                          Active_o,
    output logic                          Commit_o
);

    localparam int c_OW = $clog2(g_requesters);
    localparam int c_HW = $clog2(g_min_hold_frames) + 1;
    localparam int c_BW = $clog2(g_blink_frames) + 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST  = c_HW'(g_min_hold_frames - 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(g_blink_frames - 1);
    localparam logic [c_OW-1:0] c_PTR_RESET  = c_OW'(g_requesters - 1);
    localparam logic [g_requesters-1:0] c_ONE = g_requesters'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    logic w_clk;
    logic w_rst;
    assign w_clk = ClkRs_ix[1];
    assign w_rst = ClkRs_ix[0];

    state_t                  state_q, state_d;
    logic [c_OW-1:0]         rrPtr_q, rrPtr_d;
    logic [c_HW-1:0]         holdCnt_q, holdCnt_d;
    logic [c_BW-1:0]         blinkCnt_q, blinkCnt_d;
    logic                    blinkPhase_q, blinkPhase_d;
    logic [127:0]            ledData_q, ledData_d;
    logic [g_requesters-1:0] grant_q, grant_d;
    logic                    active_q, active_d;
    logic                    commit_q;

    logic [g_requesters-1:0] w_mask;
    logic                    w_found;
    logic [c_OW-1:0]         w_next;

    // While owned, rrPtr is the owner; it is masked so a search never re-picks it.
    always_comb begin
        w_mask  = (state_q == OWNED) ? (Request_ib & ~(c_ONE << rrPtr_q)) : Request_ib;
        w_found = 1'b0;
        w_next  = '0;
        // Walk farthest-first so the nearest hit after rrPtr is written last.
        for (int k = g_requesters; k >= 1; k--) begin
            if (w_mask[(int'(rrPtr_q) + k) % g_requesters]) begin
                w_found = 1'b1;
                w_next  = c_OW'((int'(rrPtr_q) + k) % g_requesters);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rrPtr_d      = rrPtr_q;
        holdCnt_d    = holdCnt_q;
        blinkCnt_d   = blinkCnt_q;
        blinkPhase_d = blinkPhase_q;
        ledData_d    = ledData_q;
        grant_d      = grant_q;
        active_d     = active_q;

        if (FrameDone_i) begin
            if (blinkCnt_q == c_BLINK_LAST) begin
                blinkCnt_d   = '0;
                blinkPhase_d = ~blinkPhase_q;
            end else begin
                blinkCnt_d = blinkCnt_q + c_BW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        state_d   = OWNED;
                        rrPtr_d   = w_next;
                        holdCnt_d = '0;
                    end
                end
                OWNED: begin
                    if (Request_ib[rrPtr_q] && (holdCnt_q < c_HOLD_LAST)) begin
                        holdCnt_d = holdCnt_q + c_HW'(1);
                    end else if (w_found) begin
                        rrPtr_d   = w_next;
                        holdCnt_d = '0;
                    end else if (!Request_ib[rrPtr_q]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Blink uses the phase in force before this frame's toggle.
            if (state_d == OWNED) begin
                ledData_d = (Blink_ib[rrPtr_d] && blinkPhase_q) ? '0
                          : ReqData_ib[int'(rrPtr_d)*128 +: 128];
                grant_d   = c_ONE << rrPtr_d;
                active_d  = 1'b1;
            end else begin
                ledData_d = Default_ib;
                grant_d   = '0;
                active_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q      <= IDLE;
            rrPtr_q      <= c_PTR_RESET;
            holdCnt_q    <= '0;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
            ledData_q    <= '0;
            grant_q      <= '0;
            active_q     <= 1'b0;
            commit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rrPtr_q      <= rrPtr_d;
            holdCnt_q    <= holdCnt_d;
            blinkCnt_q   <= blinkCnt_d;
            blinkPhase_q <= blinkPhase_d;
            ledData_q    <= ledData_d;
            grant_q      <= grant_d;
            active_q     <= active_d;
            commit_q     <= FrameDone_i;
        end
    end

    assign ledData_ob = ledData_q;
    assign Grant_ob   = grant_q;
    assign Active_o   = active_q;
    assign Commit_o   = commit_q;

endmodule

`default_nettype wire

// File: tb/tb_led_display_scheduler.sv
// ============================================================================
// Module   : tb_led_display_scheduler
// Purpose  : Directed plus randomized bench against a frame-level owner model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_display_scheduler;

    localparam int N = 3;
    localparam int H = 2;
    localparam int B = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fd  = 1'b0;
    logic [N-1:0]       req = '0;
    logic [N-1:0]       blk = '0;
    logic [N*128-1:0]   rdata = '0;
    logic [127:0]       dflt = '0;
    logic [127:0]       led;
    logic [N-1:0]       grant;
    logic               active;
    logic               commit;
    logic [1:0]         clkrs;

    assign clkrs = {clk, rst};

    led_display_scheduler #(
        .g_requesters     (N),
        .g_min_hold_frames(H),
        .g_blink_frames   (B)
    ) dut (
        .ClkRs_ix   (clkrs),
        .FrameDone_i(fd),
        .Request_ib (req),
        .Blink_ib   (blk),
        .ReqData_ib (rdata),
        .Default_ib (dflt),
        .ledData_ob (led),
        .Grant_ob   (grant),
        .Active_o   (active),
        .Commit_o   (commit)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: owner is an integer index, -1 meaning nobody.
    int           m_owner = -1;
    int           m_hold  = 0;
    int           m_rr    = N-1;
    int           m_bcnt  = 0;
    bit           m_phase = 1'b0;
    logic [127:0] m_led   = '0;
    bit           m_commit = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int search_from(input int start, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++)
            if (mask[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_edge();
        int nxt;
        logic [N-1:0] others;
        if (rst) begin
            m_owner = -1; m_hold = 0; m_rr = N-1; m_bcnt = 0; m_phase = 0;
            m_led = '0; m_commit = 0;
            return;
        end
        m_commit = fd;
        if (!fd) return;
        if (m_owner < 0) begin
            nxt = search_from(m_rr, req);
            if (nxt >= 0) begin m_owner = nxt; m_hold = 0; m_rr = nxt; end
        end else if (req[m_owner] && m_hold < H-1) begin
            m_hold++;
        end else begin
            others = req;
            others[m_owner] = 1'b0;
            nxt = search_from(m_owner, others);
            if (nxt >= 0) begin m_owner = nxt; m_hold = 0; m_rr = nxt; end
            else if (!req[m_owner]) m_owner = -1;
        end
        if (m_owner < 0) m_led = dflt;
        else if (blk[m_owner] && m_phase) m_led = '0;
        else m_led = rdata[m_owner*128 +: 128];
        if (m_bcnt == B-1) begin m_bcnt = 0; m_phase = !m_phase; end
        else m_bcnt++;
    endtask

    task automatic tick();
        logic [N-1:0] eg;
        model_edge();
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        @(posedge clk);
        #1;
        check("led",    led,            m_led);
        check("grant",  128'(grant),    128'(eg));
        check("active", 128'(active),   128'(m_owner >= 0));
        check("commit", 128'(commit),   128'(m_commit));
    endtask

    task automatic do_reset();
        rst = 1'b1; fd = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    logic [N-1:0] exp_t2 [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    logic [127:0] d0;

    initial begin
        for (int i = 0; i < N; i++) rdata[i*128 +: 128] = rand128();

        // 1: reset state, then idle frame shows the default pattern
        do_reset();
        check("rst_led", led, 128'h0);
        dflt = {16{8'hA5}};
        fd = 1; tick();
        check("t1_led", led, {16{8'hA5}});
        fd = 0; tick();
        check("t1_commit_low", 128'(commit), 128'h0);

        // 2: all requesting, min hold of 2 frames, rotate 0,0,1,1,2,2
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            fd = 1; tick();
            check("t2_grant", 128'(grant), 128'(exp_t2[i]));
            fd = 0; tick();
        end

        // 3: only req1, then mid-frame hand over to req2
        req = 3'b010;
        for (int i = 0; i < 5; i++) begin fd = 1; tick(); fd = 0; tick(); end
        check("t3_grant", 128'(grant), 128'(3'b010));
        req = 3'b100; fd = 0;
        tick(); tick();
        check("t3_hold_led", led, rdata[1*128 +: 128]);
        fd = 1; tick(); fd = 0;
        check("t3_switch", 128'(grant), 128'(3'b100));

        // 4: blinking owner from fresh blink counter
        do_reset();
        req = 3'b001; blk = 3'b001;
        d0 = rdata[127:0];
        for (int i = 0; i < 12; i++) begin
            fd = 1; tick();
            check("t4_led", led, (i >= 4 && i < 8) ? 128'h0 : d0);
            check("t4_grant", 128'(grant), 128'(3'b001));
        end
        blk = '0;

        // 5: data churns between pulses; only the pulse-cycle value commits
        for (int i = 0; i < 4; i++) begin
            fd = 0;
            for (int c = 0; c < 3; c++) begin rdata[127:0] = rand128(); tick(); end
            rdata[127:0] = rand128(); d0 = rdata[127:0];
            fd = 1; tick();
            check("t5_led", led, d0);
        end

        // 6: reset coincident with a frame pulse while owning
        rst = 1; fd = 1; tick();
        check("t6_led", led, 128'h0);
        check("t6_grant", 128'(grant), 128'h0);
        rst = 0; fd = 0; req = 3'b101; tick();
        fd = 1; tick(); fd = 0;
        check("t6_first", 128'(grant), 128'(3'b001));

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            fd  = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 15) == 0) blk = N'($urandom);
            if ($urandom_range(0, 1) == 0) rdata[$urandom_range(0, N-1)*128 +: 128] = rand128();
            if ($urandom_range(0, 31) == 0) dflt = rand128();
            tick();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
